// File: rtl/lift_pkg.sv
// Shared types and constants for the N-floor lift controller.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } lift_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_req_scan.sv
// Combinational scan of the pending set relative to the current floor.
module lift_req_scan #(
    parameter int FLOORS = 8,
    parameter int FW     = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0] pending,
    input  logic [FW-1:0]     cur_floor,
    output logic              any_above,
    output logic              any_below,
    output logic              here
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (FW'(i) > cur_floor)) any_above = 1'b1;
            if (pending[i] && (FW'(i) < cur_floor)) any_below = 1'b1;
        end
    end

    assign here = pending[cur_floor];

endmodule

// File: rtl/lift_ctrl_n.sv
// N-floor SCAN lift controller with per-floor travel time and door dwell.
// Optional emergency stop (estop input, halted output) under LIFT_ESTOP_EN.
module lift_ctrl_n
    import lift_pkg::*;
#(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FLOORS-1:0]         req,
`ifdef LIFT_ESTOP_EN
    input  logic                      estop,
`endif
    output logic [FLOORS-1:0]         at_floor,
    output logic [$clog2(FLOORS)-1:0] cur_floor,
    output logic                      moving_up,
    output logic                      moving_down,
    output logic                      door_open,
    output logic [FLOORS-1:0]         pending,
`ifdef LIFT_ESTOP_EN
    output logic                      halted,
`endif
    output logic [1:0]                state_dbg
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_MOVE_UP   = MOVE_UP;
    localparam logic [1:0] S_MOVE_DOWN = MOVE_DOWN;
    localparam logic [1:0] S_DOOR_OPEN = DOOR_OPEN;

    logic [1:0]        state_q, state_d;
    logic [FW-1:0]     cur_q, cur_d;
    logic [FLOORS-1:0] pend_q, pend_d, clr;
    logic [TW-1:0]     trav_q, trav_d;
    logic [DW-1:0]     door_q, door_d;
    logic              dir_q, dir_d;
    logic              any_above, any_below, here;
    logic              go_up, go_down, hold;
    logic [FW-1:0]     nf_up, nf_dn;

`ifdef LIFT_ESTOP_EN
    assign hold   = estop;
    assign halted = estop && ((state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN));
`else
    assign hold = 1'b0;
`endif

    lift_req_scan #(.FLOORS(FLOORS), .FW(FW)) u_scan (
        .pending   (pend_q),
        .cur_floor (cur_q),
        .any_above (any_above),
        .any_below (any_below),
        .here      (here)
    );

    // Work in the last travelled direction wins; otherwise take whichever side has work.
    assign go_up   = any_above && (!any_below || (dir_q == DIR_UP));
    assign go_down = any_below && !go_up;
    assign nf_up   = cur_q + FW'(1);
    assign nf_dn   = cur_q - FW'(1);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        trav_d  = trav_q;
        door_d  = door_q;
        dir_d   = dir_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d     = S_DOOR_OPEN;
                    door_d      = '0;
                    clr[cur_q]  = 1'b1;
                end else if (!hold && go_up) begin
                    state_d = S_MOVE_UP;
                    dir_d   = DIR_UP;
                    trav_d  = '0;
                end else if (!hold && go_down) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                    trav_d  = '0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (!hold) begin
                    if (trav_q == TRAV_LAST) begin
                        trav_d = '0;
                        cur_d  = (state_q == S_MOVE_UP) ? nf_up : nf_dn;
                        if (pend_q[cur_d]) begin
                            state_d    = S_DOOR_OPEN;
                            door_d     = '0;
                            clr[cur_d] = 1'b1;
                        end
                    end else begin
                        trav_d = trav_q + TW'(1);
                    end
                end
            end
            S_DOOR_OPEN: begin
                // A call for this floor while open only extends the dwell.
                clr[cur_q] = 1'b1;
                if (req[cur_q]) begin
                    door_d = '0;
                end else if (!hold) begin
                    if (door_q == DOOR_LAST) begin
                        door_d = '0;
                        if (go_up) begin
                            state_d = S_MOVE_UP;
                            dir_d   = DIR_UP;
                            trav_d  = '0;
                        end else if (go_down) begin
                            state_d = S_MOVE_DOWN;
                            dir_d   = DIR_DOWN;
                            trav_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        door_d = door_q + DW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pend_d = (pend_q | req) & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            pend_q  <= '0;
            trav_q  <= '0;
            door_q  <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            trav_q  <= trav_d;
            door_q  <= door_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        for (int i = 0; i < FLOORS; i++) begin
            at_floor[i] = (cur_q == FW'(i));
        end
    end

    assign cur_floor   = cur_q;
    assign moving_up   = (state_q == S_MOVE_UP);
    assign moving_down = (state_q == S_MOVE_DOWN);
    assign door_open   = (state_q == S_DOOR_OPEN);
    assign pending     = pend_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Bench for lift_ctrl_n (8 floors, 2 travel cycles, 3 door cycles); estop checks under LIFT_ESTOP_EN.
module tb_lift_ctrl_n;

    localparam int FLOORS = 8;
    localparam int TRAVEL = 2;
    localparam int DOOR   = 3;
    localparam int W      = 22;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] at_floor;
    logic [2:0] cur_floor;
    logic       moving_up, moving_down, door_open;
    logic [7:0] pending;
    logic [1:0] state_dbg;
`ifdef LIFT_ESTOP_EN
    logic estop;
    logic halted;
`endif

    always #5 clk = ~clk;

    lift_ctrl_n #(.FLOORS(FLOORS), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
`ifdef LIFT_ESTOP_EN
        .estop       (estop),
`endif
        .at_floor    (at_floor),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending),
`ifdef LIFT_ESTOP_EN
        .halted      (halted),
`endif
        .state_dbg   (state_dbg)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: floor number, activity, countdown to the next event.
    int         m_floor, m_mode, m_left;
    bit         m_up;
    logic [7:0] m_pend;
    bit         m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit work_above(input logic [7:0] p, input int f);
        for (int j = f + 1; j < FLOORS; j++) if (p[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit work_below(input logic [7:0] p, input int f);
        for (int j = 0; j < f; j++) if (p[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0;
        m_mode  = M_IDLE;
        m_left  = 0;
        m_up    = 1'b1;
        m_pend  = 8'h00;
        m_halt  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] r, input bit e);
        logic [7:0] p, clr;
        bit ab, be, gu, gd;
        p   = m_pend;
        clr = 8'h00;
        ab  = work_above(p, m_floor);
        be  = work_below(p, m_floor);
        gu  = ab && (m_up || !be);
        gd  = be && !gu;
        case (m_mode)
            M_IDLE: begin
                if (p[m_floor]) begin
                    m_mode = M_DOOR; m_left = DOOR; clr[m_floor] = 1'b1;
                end else if (!e && (gu || gd)) begin
                    m_mode = gu ? M_UP : M_DOWN; m_up = gu; m_left = TRAVEL;
                end
            end
            M_UP, M_DOWN: begin
                if (!e) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor += (m_mode == M_UP) ? 1 : -1;
                        m_left = TRAVEL;
                        if (p[m_floor]) begin
                            m_mode = M_DOOR; m_left = DOOR; clr[m_floor] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                clr[m_floor] = 1'b1;
                if (r[m_floor]) m_left = DOOR;
                else if (!e) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (gu || gd) begin
                            m_mode = gu ? M_UP : M_DOWN; m_up = gu; m_left = TRAVEL;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
        endcase
        m_pend = (p | r) & ~clr;
        m_halt = e && (m_mode == M_UP || m_mode == M_DOWN);
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, compare 1 time unit later.
    task automatic tick(input logic [7:0] r, input bit e);
        bit e_used;
        logic [7:0] a;
        logic [W-1:0] exp_v, act_v;
        e_used = 1'b0;
        req = r;
`ifdef LIFT_ESTOP_EN
        estop  = e;
        e_used = e;
`endif
        @(posedge clk);
        model_step(r, e_used);
        a = 8'h01;
        a = a << m_floor;
        exp_q.push_back({a, 3'(m_floor), (m_mode == M_UP), (m_mode == M_DOWN),
                         (m_mode == M_DOOR), m_pend});
        #1;
        act_v = {at_floor, cur_floor, moving_up, moving_down, door_open, pending};
        exp_v = exp_q.pop_front();
        check("model", 32'(act_v), 32'(exp_v));
`ifdef LIFT_ESTOP_EN
        check("halted", 32'(halted), 32'(m_halt));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_at_floor"}, 32'(at_floor), 32'h01);
        check({tag, "_cur"}, 32'(cur_floor), 32'd0);
        check({tag, "_pend"}, 32'(pending), 32'h00);
        check({tag, "_motion"}, 32'({moving_up, moving_down, door_open}), 32'd0);
    endtask

    task automatic do_reset();
        req = 8'h00;
`ifdef LIFT_ESTOP_EN
        estop = 1'b0;
`endif
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic [2:0] cur;
        logic       mu;
        logic       md;
        logic       door;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[10];
    int   s;
    int   door_cnt;
    bit   est;

    initial begin
        reset = 1'b0;
        req   = 8'h00;
`ifdef LIFT_ESTOP_EN
        estop = 1'b0;
`endif
        // Single call to floor 2 from reset, edge by edge from E1.
        vecs[0] = '{8'h04, 3'd0, 1'b0, 1'b0, 1'b0, 8'h04};
        vecs[1] = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h04};
        vecs[2] = '{8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h04};
        vecs[3] = '{8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h04};
        vecs[4] = '{8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h04};
        vecs[5] = '{8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[7] = '{8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[8] = '{8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].req, 1'b0);
            check($sformatf("v%0d_cur", i), 32'(cur_floor), 32'(vecs[i].cur));
            check($sformatf("v%0d_dir", i), 32'({moving_up, moving_down}),
                  32'({vecs[i].mu, vecs[i].md}));
            check($sformatf("v%0d_door", i), 32'(door_open), 32'(vecs[i].door));
            check($sformatf("v%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
        end

        // Calls above and below from floor 2, last direction up: top first, then bottom.
        tick(8'h81, 1'b0);
        check("scan_start_pend", 32'(pending), 32'h81);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);
        check("scan_pre7_door", 32'(door_open), 32'd0);
        tick(8'h00, 1'b0);
        check("scan_at7", 32'({cur_floor, door_open}), 32'({3'd7, 1'b1}));
        check("scan_pend_after7", 32'(pending), 32'h01);
        for (int i = 0; i < 17; i++) tick(8'h00, 1'b0);
        check("scan_at0", 32'({cur_floor, door_open}), 32'({3'd0, 1'b1}));
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        check("scan_idle", 32'({moving_up, moving_down, door_open}), 32'd0);
        check("scan_pend_end", 32'(pending), 32'h00);

        // Intermediate call for floor 3 injected while travelling 1 -> 2 toward 6.
        tick(8'h40, 1'b0);
        tick(8'h00, 1'b0);
        check("mid_move", 32'(moving_up), 32'd1);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        check("mid_floor1", 32'(cur_floor), 32'd1);
        tick(8'h08, 1'b0);
        tick(8'h00, 1'b0);
        check("mid_pass2", 32'({cur_floor, door_open}), 32'({3'd2, 1'b0}));
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        check("mid_stop3", 32'({cur_floor, door_open}), 32'({3'd3, 1'b1}));
        check("mid_pend", 32'(pending), 32'h40);

        // Repeat call at the open floor during the second door cycle extends the dwell.
        door_cnt = 1;
        tick(8'h00, 1'b0);
        door_cnt += door_open;
        tick(8'h08, 1'b0);
        door_cnt += door_open;
        check("reopen_pend3", 32'(pending[3]), 32'd0);
        tick(8'h00, 1'b0);
        door_cnt += door_open;
        tick(8'h00, 1'b0);
        door_cnt += door_open;
        tick(8'h00, 1'b0);
        door_cnt += door_open;
        check("reopen_cycles", 32'(door_cnt), 32'd5);
        check("reopen_leave", 32'(moving_up), 32'd1);
        for (int i = 0; i < 6; i++) tick(8'h00, 1'b0);
        check("mid_stop6", 32'({cur_floor, door_open}), 32'({3'd6, 1'b1}));

        // Asynchronous reset mid-travel at floor 4.
        do_reset();
        tick(8'h80, 1'b0);
        for (int i = 0; i < 40 && cur_floor != 3'd4; i++) tick(8'h00, 1'b0);
        check("reach_floor4", 32'(cur_floor), 32'd4);
        tick(8'h00, 1'b0);
        check("mid_travel4", 32'({cur_floor, moving_up}), 32'({3'd4, 1'b1}));
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifdef LIFT_ESTOP_EN
        // Emergency stop for four edges while travelling 0 -> 3.
        do_reset();
        tick(8'h08, 1'b0);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        check("estop_floor1", 32'(cur_floor), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(8'h00, 1'b1);
            check("estop_hold", 32'({cur_floor, halted, moving_up}), 32'({3'd1, 1'b1, 1'b1}));
        end
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        check("estop_not_yet", 32'(door_open), 32'd0);
        tick(8'h00, 1'b0);
        check("estop_arrive", 32'({cur_floor, door_open, halted}), 32'({3'd3, 1'b1, 1'b0}));
`endif

        // Random calls (and stops, when built in) against the reference model.
        do_reset();
        est = 1'b0;
        for (int i = 0; i < 800; i++) begin
            s = $urandom_range(0, 5);
            if ($urandom_range(0, 24) == 0) est = ~est;
            tick((s == 0) ? 8'($urandom_range(0, 255)) : 8'h00, est);
        end
        for (int i = 0; i < 60; i++) tick(8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
